oms_lut_mult: RTL and testbench



---
 rtl/oms_pkg.sv | 28 ++
 rtl/oms_digit_decode.sv | 43 ++++
 rtl/oms_lut_mult.sv | 179 +++++++++++++++++
 tb/tb_oms_lut_mult.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/oms_pkg.sv
// ---------------------------------------------------------------------------
// oms_pkg
// Shared constants, state type and helpers for the odd-multiple-storage (OMS)
// LUT multiplier.
//   LUT_DEPTH       : number of stored odd multiples (1A, 3A, ... 15A)
//   DIGIT_W         : operand digit width consumed per BUSY cycle
//   oms_state_t     : controller states
//   lut_entry_width : width needed to hold 15*A without overflow
// ---------------------------------------------------------------------------
package oms_pkg;

  localparam int LUT_DEPTH = 8;
  localparam int DIGIT_W   = 4;

  typedef enum logic [2:0] {
    EMPTY,
    LOAD,
    READY,
    BUSY,
    DONE
  } oms_state_t;

  // 15*A < 16*A, so four extra bits always suffice.
  function automatic int lut_entry_width(input int a_w);
    return a_w + 4;
  endfunction

endpackage

// File: rtl/oms_digit_decode.sv
// ---------------------------------------------------------------------------
// oms_digit_decode
// Splits a 4-bit operand digit n into n = odd * 2^shift and maps the odd
// factor to its LUT address (odd-1)/2. A zero digit raises 'zero' so the
// partial product can be forced to 0.
//   digit : 4-bit operand digit
//   addr  : LUT address of the odd factor (0..7)
//   shift : power-of-two factor (0..3)
//   zero  : digit is zero, partial product must be 0
// ---------------------------------------------------------------------------
module oms_digit_decode
  import oms_pkg::*;
(
  input  logic [DIGIT_W-1:0] digit,
  output logic [2:0]         addr,
  output logic [1:0]         shift,
  output logic               zero
);

  // The shift is the number of trailing zeros; the odd factor is what remains
  // above them, and dropping its (always set) LSB gives the address.
  always_comb begin
    addr  = '0;
    shift = '0;
    zero  = 1'b0;
    if (digit[0]) begin
      addr  = digit[3:1];
      shift = 2'd0;
    end else if (digit[1]) begin
      addr  = {1'b0, digit[3:2]};
      shift = 2'd1;
    end else if (digit[2]) begin
      addr  = {2'b00, digit[3]};
      shift = 2'd2;
    end else if (digit[3]) begin
      addr  = 3'd0;
      shift = 2'd3;
    end else begin
      zero  = 1'b1;
    end
  end

endmodule

// File: rtl/oms_lut_mult.sv
// ---------------------------------------------------------------------------
// oms_lut_mult
// Sequential OMS LUT multiplier. A loaded coefficient A is expanded into the
// eight odd multiples 1A..15A with a running adder (no multiplier). An
// operand X is then multiplied one 4-bit digit per cycle, LSB digit first,
// by accumulating shifted LUT entries.
//   clk, rst              : clock, asynchronous active-high reset
//   coef_valid/ready/coef : coefficient load handshake
//   in_valid/ready/x      : operand handshake
//   out_valid/ready       : product handshake
//   product               : A*X, held until the next result or reset
//   lut_ok                : LUT holds a complete coefficient set
// ---------------------------------------------------------------------------
module oms_lut_mult
  import oms_pkg::*;
#(
  parameter int A_W = 8,
  parameter int X_W = 16,
  parameter int P_W = A_W + X_W
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           coef_valid,
  output logic           coef_ready,
  input  logic [A_W-1:0] coef,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [X_W-1:0] x,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [P_W-1:0] product,
  output logic           lut_ok
);

  localparam int E_W        = lut_entry_width(A_W);
  localparam int NUM_DIGITS = X_W / DIGIT_W;
  localparam int J_W        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
  localparam logic [J_W-1:0] LAST_J = J_W'(NUM_DIGITS - 1);
  localparam logic [2:0]     LAST_K = 3'(LUT_DEPTH - 1);

  oms_state_t state, state_next;

  logic coef_take;
  logic x_take;

  logic [E_W-1:0] lut [LUT_DEPTH];
  logic [E_W-1:0] run_sum;
  logic [E_W-1:0] two_a;
  logic [2:0]     k;

  logic [X_W-1:0] x_shift;
  logic [J_W-1:0] j;
  logic [P_W-1:0] acc;
  logic [P_W-1:0] product_q;
  logic           lut_ok_q;

  logic [2:0]     dig_addr;
  logic [1:0]     dig_shift;
  logic           dig_zero;
  logic [P_W-1:0] entry_ext;
  logic [P_W-1:0] partial;
  logic [P_W-1:0] acc_next;
  logic [J_W+1:0] digit_pos;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= EMPTY;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and handshake outputs. A coefficient request in READY takes
  // priority over an operand, so in_ready is withdrawn combinationally while
  // coef_valid is high to keep the operand from being consumed.
  always_comb begin
    state_next = state;
    coef_ready = 1'b0;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    coef_take  = 1'b0;
    x_take     = 1'b0;
    unique case (state)
      EMPTY: begin
        coef_ready = 1'b1;
        if (coef_valid) begin
          coef_take  = 1'b1;
          state_next = LOAD;
        end
      end
      LOAD: begin
        if (k == LAST_K) state_next = READY;
      end
      READY: begin
        coef_ready = 1'b1;
        in_ready   = !coef_valid;
        if (coef_valid) begin
          coef_take  = 1'b1;
          state_next = LOAD;
        end else if (in_valid) begin
          x_take     = 1'b1;
          state_next = BUSY;
        end
      end
      BUSY: begin
        if (j == LAST_J) state_next = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = READY;
      end
      default: state_next = EMPTY;
    endcase
  end

  oms_digit_decode u_digit_decode (
    .digit (x_shift[DIGIT_W-1:0]),
    .addr  (dig_addr),
    .shift (dig_shift),
    .zero  (dig_zero)
  );

  // Partial product of the current digit. digit_pos is the digit index times
  // four, i.e. the weight of the digit within X.
  always_comb begin
    entry_ext = P_W'(lut[dig_addr]);
    digit_pos = {j, 2'b00};
    partial   = '0;
    if (!dig_zero) partial = (entry_ext << dig_shift) << digit_pos;
    acc_next  = acc + partial;
  end

  // LUT fill, accumulator and result registers. During LOAD the running sum
  // steps A, 3A, 5A, ... by adding 2A, writing one entry per cycle. During
  // BUSY the operand is shifted right so the current digit is always in the
  // low nibble; the final sum is captured into the product register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < LUT_DEPTH; i++) lut[i] <= '0;
      run_sum   <= '0;
      two_a     <= '0;
      k         <= '0;
      x_shift   <= '0;
      j         <= '0;
      acc       <= '0;
      product_q <= '0;
      lut_ok_q  <= 1'b0;
    end else begin
      if (coef_take) begin
        run_sum  <= E_W'(coef);
        two_a    <= E_W'(coef) << 1;
        k        <= '0;
        lut_ok_q <= 1'b0;
      end
      if (state == LOAD) begin
        lut[k]  <= run_sum;
        run_sum <= run_sum + two_a;
        k       <= k + 1'b1;
        if (k == LAST_K) lut_ok_q <= 1'b1;
      end
      if (x_take) begin
        x_shift <= x;
        acc     <= '0;
        j       <= '0;
      end
      if (state == BUSY) begin
        acc     <= acc_next;
        x_shift <= x_shift >> DIGIT_W;
        j       <= j + 1'b1;
        if (j == LAST_J) product_q <= acc_next;
      end
    end
  end

  assign product = product_q;
  assign lut_ok  = lut_ok_q;

endmodule

// File: tb/tb_oms_lut_mult.sv
// ---------------------------------------------------------------------------
// tb_oms_lut_mult
// Self-checking bench for oms_lut_mult. Expected products come from plain
// A*X arithmetic on the bench's own copy of the loaded coefficient; expected
// LUT contents are (2k+1)*A.
// ---------------------------------------------------------------------------
module tb_oms_lut_mult;

  localparam int A_W = 8;
  localparam int X_W = 16;
  localparam int P_W = A_W + X_W;

  logic           clk = 1'b0;
  logic           rst;
  logic           coef_valid;
  logic           coef_ready;
  logic [A_W-1:0] coef;
  logic           in_valid;
  logic           in_ready;
  logic [X_W-1:0] x;
  logic           out_valid;
  logic           out_ready;
  logic [P_W-1:0] product;
  logic           lut_ok;

  int checks   = 0;
  int failures = 0;

  logic [A_W-1:0] modelA;

  oms_lut_mult #(
    .A_W (A_W),
    .X_W (X_W),
    .P_W (P_W)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .coef_valid (coef_valid),
    .coef_ready (coef_ready),
    .coef       (coef),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .x          (x),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .product    (product),
    .lut_ok     (lut_ok)
  );

  always #5 clk = ~clk;

  // Safety net so the run always ends.
  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  task automatic checkResetValues(input string tag);
    checkOutput({tag, "_coef_ready"}, coef_ready, 1);
    checkOutput({tag, "_in_ready"},   in_ready,   0);
    checkOutput({tag, "_out_valid"},  out_valid,  0);
    checkOutput({tag, "_product"},    product,    0);
    checkOutput({tag, "_lut_ok"},     lut_ok,     0);
  endtask

  // Loads a coefficient, checks the 8-cycle LOAD window and optionally the
  // stored odd multiples. Starts and ends on a falling edge.
  task automatic loadCoef(input logic [A_W-1:0] a, input bit checkLut);
    int n;
    n = 0;
    while (!coef_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("coef_ready_wait", coef_ready, 1);
    coef       = a;
    coef_valid = 1'b1;
    @(negedge clk);
    coef_valid = 1'b0;
    modelA     = a;
    checkOutput("load_coef_ready", coef_ready, 0);
    checkOutput("load_in_ready",   in_ready,   0);
    for (int i = 0; i <= 8; i++) begin
      if (i > 0) @(negedge clk);
      checkOutput($sformatf("lut_ok_cycle_%0d", i), lut_ok, (i == 8) ? 1 : 0);
    end
    if (checkLut) begin
      for (int i = 0; i < 8; i++) begin
        checkOutput($sformatf("lut_entry_%0d", i), 64'(dut.lut[i]), 64'((2 * i + 1) * int'(a)));
      end
    end
  endtask

  // One multiply transaction: checks latency, product against A*X, optional
  // backpressure hold of holdCycles, and the return to READY.
  task automatic applyStimulus(input logic [X_W-1:0] xv, input int holdCycles);
    logic [63:0] expProd;
    int n;
    expProd = 64'(modelA) * 64'(xv);
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    checkOutput("in_ready_wait", in_ready, 1);
    x         = xv;
    in_valid  = 1'b1;
    out_ready = (holdCycles == 0);
    @(negedge clk);
    in_valid = 1'b0;
    checkOutput("busy_coef_ready", coef_ready, 0);
    checkOutput("busy_in_ready",   in_ready,   0);
    n = 1;
    while (!out_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    checkOutput("latency", n, 5);
    checkOutput($sformatf("product_x%04h", xv), product, expProd);
    for (int i = 0; i < holdCycles; i++) begin
      @(negedge clk);
      checkOutput("hold_out_valid",  out_valid,  1);
      checkOutput("hold_product",    product,    expProd);
      checkOutput("hold_coef_ready", coef_ready, 0);
      checkOutput("hold_in_ready",   in_ready,   0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    checkOutput("post_out_valid",   out_valid, 0);
    checkOutput("post_in_ready",    in_ready,  1);
    checkOutput("post_product_held", product,  expProd);
  endtask

  initial begin
    int n;
    logic [X_W-1:0] xv;
    logic [A_W-1:0] av;

    rst        = 1'b1;
    coef_valid = 1'b0;
    coef       = '0;
    in_valid   = 1'b0;
    x          = '0;
    out_ready  = 1'b1;
    modelA     = '0;
    #12;
    checkResetValues("reset");
    @(negedge clk);
    rst = 1'b0;

    // Operands are ignored while no coefficient is loaded.
    in_valid = 1'b1;
    x        = 16'h0011;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checkOutput("empty_in_ready",  in_ready,  0);
      checkOutput("empty_out_valid", out_valid, 0);
    end
    in_valid = 1'b0;

    // Directed cases.
    loadCoef(8'd13, 1'b1);
    applyStimulus(16'h00F0, 0);
    applyStimulus(16'h0000, 0);
    loadCoef(8'd255, 1'b1);
    applyStimulus(16'hFFFF, 0);
    loadCoef(8'd1, 1'b0);
    applyStimulus(16'h8421, 0);

    // Backpressure in DONE.
    loadCoef(8'd13, 1'b0);
    applyStimulus(16'h1357, 10);

    // Coefficient and operand presented together: the coefficient wins.
    coef       = 8'd7;
    coef_valid = 1'b1;
    x          = 16'd3;
    in_valid   = 1'b1;
    #1;
    checkOutput("collide_in_ready",   in_ready,   0);
    checkOutput("collide_coef_ready", coef_ready, 1);
    @(negedge clk);
    coef_valid = 1'b0;
    in_valid   = 1'b0;
    modelA     = 8'd7;
    checkOutput("collide_lut_ok_drop", lut_ok,    0);
    checkOutput("collide_out_valid",   out_valid, 0);
    n = 0;
    while (!lut_ok && n < 30) begin
      @(negedge clk);
      n++;
    end
    checkOutput("collide_load_len",    n,         8);
    checkOutput("collide_no_product",  out_valid, 0);
    applyStimulus(16'd3, 0);

    // Reset in the second BUSY cycle aborts and invalidates the LUT.
    loadCoef(8'd200, 1'b0);
    x        = 16'h1234;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    #1;
    checkResetValues("midbusy_reset");
    @(negedge clk);
    rst = 1'b0;
    in_valid = 1'b1;
    x        = 16'd5;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      checkOutput("after_reset_in_ready",  in_ready,  0);
      checkOutput("after_reset_out_valid", out_valid, 0);
      checkOutput("after_reset_lut_ok",    lut_ok,    0);
    end
    in_valid = 1'b0;
    loadCoef(8'd9, 1'b1);
    applyStimulus(16'd5, 0);

    // Randomized coefficients and operands, with zero digits sprinkled in.
    for (int t = 0; t < 12; t++) begin
      av = 8'($urandom_range(0, 255));
      if (t == 0) av = 8'd0;
      loadCoef(av, 1'b1);
      for (int r = 0; r < 3; r++) begin
        xv = 16'($urandom);
        for (int d = 0; d < 4; d++) begin
          if ($urandom_range(0, 3) == 0) xv[d*4 +: 4] = 4'h0;
        end
        applyStimulus(xv, (r == 2) ? int'($urandom_range(0, 3)) : 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
